// File: rtl/sb_hazard_ctrl_pkg.sv
// rtl/sb_hazard_ctrl_pkg.sv - shared constants and decode helper for the RAW scoreboard
// Contents:
//   SB_NREG          number of GPRs tracked (entry 0 is never used)
//   SB_AW            GPR index width
//   SB_CNT_W         default per-entry counter width
//   SB_MAX_INFLIGHT  default saturation point (EXE + MEM + WB writers)
//   sb_onehot()      register-index decode that never selects $0
package sb_hazard_ctrl_pkg;

    localparam int SB_NREG         = 32;
    localparam int SB_AW           = 5;
    localparam int SB_CNT_W        = 2;
    localparam int SB_MAX_INFLIGHT = 3;

    // $0 is hard-wired to zero, so a write to it never creates a dependence.
    function automatic logic [SB_NREG-1:0] sb_onehot(input logic en,
                                                     input logic [SB_AW-1:0] addr);
        logic [SB_NREG-1:0] vec;
        vec = '0;
        if (en && (addr != '0)) begin
            vec[addr] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/sb_hazard_ctrl_entry.sv
// rtl/sb_hazard_ctrl_entry.sv - one scoreboard entry: saturating up/down writer counter
// Ports:
//   clk    in   core clock
//   reset  in   synchronous active-high reset, clears the count
//   inc    in   a writer of this GPR issues from ID this cycle
//   dec    in   WB writes this GPR this cycle
//   cnt    out  registered number of in-flight writers
//   err    out  combinational: this cycle's inc hits a full counter or dec hits an empty one
module sb_hazard_ctrl_entry #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic full;
    logic empty;

    assign full  = (cnt == MAX_CNT);
    assign empty = (cnt == '0);

    // Simultaneous inc and dec cancel, so neither can overflow or underflow.
    assign err = (inc & ~dec & full) | (dec & ~inc & empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sb_hazard_ctrl.sv
// rtl/sb_hazard_ctrl.sv - scoreboard RAW hazard controller driving stallD into ID
// Optional feature macro: SB_WB_BYPASS_EN (WB write-through suppresses the last-writer hazard)
// Ports:
//   clk, reset      core clock, synchronous active-high reset
//   ds_use_rs/rt    ID instruction reads rs / rt
//   rs_addr/rt_addr ID source indices
//   ds_issue        ID instruction moves to EXE this cycle
//   ds_gr_we        ID instruction writes a GPR
//   ds_dest         ID destination index
//   ws_rf_we        WB writes the regfile this cycle
//   ws_rf_waddr     WB write index
//   stallD          combinational hold request for ID
//   sb_err          sticky protocol error (counter overflow or underflow)
module sb_hazard_ctrl
    import sb_hazard_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int CNT_W        = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds_use_rs,
    input  logic             ds_use_rt,
    input  logic [SB_AW-1:0] rs_addr,
    input  logic [SB_AW-1:0] rt_addr,
    input  logic             ds_issue,
    input  logic             ds_gr_we,
    input  logic [SB_AW-1:0] ds_dest,
    input  logic             ws_rf_we,
    input  logic [SB_AW-1:0] ws_rf_waddr,
    output logic             stallD,
    output logic             sb_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [SB_NREG-1:0] inc_vec;
    logic [SB_NREG-1:0] dec_vec;
    logic [SB_NREG-1:0] err_vec;
    logic [CNT_W-1:0]   cnt [SB_NREG];

    assign inc_vec = sb_onehot(ds_issue & ds_gr_we, ds_dest);
    assign dec_vec = sb_onehot(ws_rf_we, ws_rf_waddr);

    for (genvar r = 0; r < SB_NREG; r++) begin : g_entry
        if (r == 0) begin : g_zero
            // sb_onehot never selects bit 0; kept only so the vectors stay full width.
            logic unused_zero;
            assign unused_zero = inc_vec[0] ^ dec_vec[0];
            assign cnt[0]      = '0;
            assign err_vec[0]  = 1'b0;
        end else begin : g_cnt
            sb_hazard_ctrl_entry #(
                .MAX_INFLIGHT (MAX_INFLIGHT),
                .CNT_W        (CNT_W)
            ) u_entry (
                .clk   (clk),
                .reset (reset),
                .inc   (inc_vec[r]),
                .dec   (dec_vec[r]),
                .cnt   (cnt[r]),
                .err   (err_vec[r])
            );
        end
    end

    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic [CNT_W-1:0] dst_cnt;
    logic             rs_bypass;
    logic             rt_bypass;
    logic             hazard_rs;
    logic             hazard_rt;
    logic             full_dst;

    assign rs_cnt  = cnt[rs_addr];
    assign rt_cnt  = cnt[rt_addr];
    assign dst_cnt = cnt[ds_dest];

`ifdef SB_WB_BYPASS_EN
    // The last outstanding writer is in WB right now and the regfile is
    // write-through, so ID reads the new value this very cycle.
    assign rs_bypass = (rs_cnt == CNT_W'(1)) & dec_vec[rs_addr];
    assign rt_bypass = (rt_cnt == CNT_W'(1)) & dec_vec[rt_addr];
`else
    assign rs_bypass = 1'b0;
    assign rt_bypass = 1'b0;
`endif

    assign hazard_rs = ds_use_rs & (rs_cnt != '0) & ~rs_bypass;
    assign hazard_rt = ds_use_rt & (rt_cnt != '0) & ~rt_bypass;

    // Checked every cycle, not only on issue, so ID never issues into a full entry.
    assign full_dst = ds_gr_we & (dst_cnt == MAX_CNT);

    assign stallD = hazard_rs | hazard_rt | full_dst;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (|err_vec) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sb_hazard_ctrl.sv
// tb/tb_sb_hazard_ctrl.sv - directed self-checking bench for sb_hazard_ctrl
module tb_sb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       ds_use_rs;
    logic       ds_use_rt;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic       ds_issue;
    logic       ds_gr_we;
    logic [4:0] ds_dest;
    logic       ws_rf_we;
    logic [4:0] ws_rf_waddr;
    logic       stallD;
    logic       sb_err;

    int vectors     = 0;
    int miscompares = 0;

    sb_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ds_use_rs   (ds_use_rs),
        .ds_use_rt   (ds_use_rt),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .ds_issue    (ds_issue),
        .ds_gr_we    (ds_gr_we),
        .ds_dest     (ds_dest),
        .ws_rf_we    (ws_rf_we),
        .ws_rf_waddr (ws_rf_waddr),
        .stallD      (stallD),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SB_WB_BYPASS_EN
    localparam logic STALL_IN_WB_CYCLE = 1'b0;
`else
    localparam logic STALL_IN_WB_CYCLE = 1'b1;
`endif

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ds_use_rs   = 1'b0;
        ds_use_rt   = 1'b0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd0;
        ds_issue    = 1'b0;
        ds_gr_we    = 1'b0;
        ds_dest     = 5'd0;
        ws_rf_we    = 1'b0;
        ws_rf_waddr = 5'd0;
    endtask

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Combinational stall probe of one register through the rs port.
    task automatic probe(input string tag, input logic [4:0] r, input logic exp);
        idle();
        ds_use_rs = 1'b1;
        rs_addr   = r;
        #1;
        chk(tag, stallD, exp);
        idle();
    endtask

    task automatic issue(input logic [4:0] d);
        idle();
        ds_issue = 1'b1;
        ds_gr_we = 1'b1;
        ds_dest  = d;
        step();
        idle();
    endtask

    task automatic retire(input logic [4:0] a);
        idle();
        ws_rf_we    = 1'b1;
        ws_rf_waddr = a;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // 1: reset state
        probe("t1_rs5", 5'd5, 1'b0);
        chk("t1_err", sb_err, 1'b0);
        for (int r = 0; r < 32; r++) begin
            probe($sformatf("t1_zero_r%0d", r), 5'(r), 1'b0);
        end

        // 2: issue dest=8, rt reader stalls until WB writes 8
        ds_issue = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd8;
        #1;
        chk("t2_c0", stallD, 1'b0);
        step();
        idle();
        ds_use_rt = 1'b1; rt_addr = 5'd8;
        #1;
        chk("t2_c1", stallD, 1'b1);
        step();
        chk("t2_c2", stallD, 1'b1);
        step();
        ws_rf_we = 1'b1; ws_rf_waddr = 5'd8;
        #1;
        chk("t2_c3", stallD, STALL_IN_WB_CYCLE);
        step();
        ws_rf_we = 1'b0; ws_rf_waddr = 5'd0;
        #1;
        chk("t2_c4", stallD, 1'b0);
        idle();

        // 3: simultaneous issue and retire on 8 keeps cnt[8]=1
        issue(5'd8);
        ds_issue = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd8;
        ws_rf_we = 1'b1; ws_rf_waddr = 5'd8;
        step();
        idle();
        ds_use_rt = 1'b1; rt_addr = 5'd8;
        #1;
        chk("t3_rt8", stallD, 1'b1);
        idle();
        retire(5'd8);
        probe("t3_drained", 5'd8, 1'b0);
        chk("t3_err", sb_err, 1'b0);

        // 4: three writers to $3 fill the entry
        issue(5'd3);
        issue(5'd3);
        issue(5'd3);
        ds_gr_we = 1'b1; ds_dest = 5'd3;
        #1;
        chk("t4_full", stallD, 1'b1);
        step();
        chk("t4_full_hold", stallD, 1'b1);
        ws_rf_we = 1'b1; ws_rf_waddr = 5'd3;
        #1;
        chk("t4_full_wb", stallD, 1'b1);
        step();
        ws_rf_we = 1'b0; ws_rf_waddr = 5'd0;
        #1;
        chk("t4_released", stallD, 1'b0);
        idle();
        probe("t4_cnt2", 5'd3, 1'b1);
        retire(5'd3);
        retire(5'd3);
        probe("t4_drained", 5'd3, 1'b0);
        chk("t4_err", sb_err, 1'b0);

        // 5: $0 is never tracked
        issue(5'd0);
        probe("t5_r0", 5'd0, 1'b0);
        ds_gr_we = 1'b1; ds_dest = 5'd0;
        #1;
        chk("t5_dst0", stallD, 1'b0);
        idle();
        retire(5'd0);
        chk("t5_err", sb_err, 1'b0);

        // Independent inc/dec on different entries
        issue(5'd12);
        ds_issue = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd11;
        ws_rf_we = 1'b1; ws_rf_waddr = 5'd12;
        step();
        idle();
        probe("ind_r11", 5'd11, 1'b1);
        probe("ind_r12", 5'd12, 1'b0);
        retire(5'd11);
        probe("ind_r11_done", 5'd11, 1'b0);
        chk("ind_err", sb_err, 1'b0);

        // 6: underflow is sticky until reset
        retire(5'd9);
        chk("t6_set", sb_err, 1'b1);
        step();
        step();
        chk("t6_sticky", sb_err, 1'b1);
        probe("t6_r9", 5'd9, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_reset", sb_err, 1'b0);

        // Saturation: a fourth issue to a full entry is dropped and flagged
        issue(5'd4);
        issue(5'd4);
        issue(5'd4);
        chk("sat_before", sb_err, 1'b0);
        issue(5'd4);
        chk("sat_err", sb_err, 1'b1);
        retire(5'd4);
        retire(5'd4);
        probe("sat_cnt1", 5'd4, 1'b1);
        retire(5'd4);
        probe("sat_cnt0", 5'd4, 1'b0);

        // Reset mid-operation clears in-flight writers
        issue(5'd10);
        issue(5'd10);
        probe("mid_busy", 5'd10, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        probe("mid_cleared", 5'd10, 1'b0);
        chk("mid_err", sb_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
